// File: rtl/jstk_spi_responder_pkg.sv
// Shared definitions for the joystick SPI responder and the joystick reader:
// frame geometry, LED command code, FSM states and the 40-bit frame layout.
package jstk_spi_responder_pkg;

    localparam int unsigned JSTK_FRAME_BITS = 40;
    localparam int unsigned JSTK_CNT_W      = 6;
    localparam int unsigned JSTK_CMD_BITS   = 8;
    localparam int unsigned JSTK_POS_W      = 10;
    localparam int unsigned JSTK_BTN_W      = 3;
    localparam logic [5:0]  JSTK_LED_CMD    = 6'b100000;

    // Byte positions within the frame, byte 0 transmitted first
    localparam int unsigned JSTK_BYTE_XLO = 0;
    localparam int unsigned JSTK_BYTE_XHI = 1;
    localparam int unsigned JSTK_BYTE_YLO = 2;
    localparam int unsigned JSTK_BYTE_YHI = 3;
    localparam int unsigned JSTK_BYTE_BTN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } jstk_state_e;

    function automatic logic [JSTK_FRAME_BITS-1:0] jstk_pack_frame(
        input logic [JSTK_POS_W-1:0] x,
        input logic [JSTK_POS_W-1:0] y,
        input logic [JSTK_BTN_W-1:0] b
    );
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

endpackage

// File: rtl/jstk_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a joystick: returns a 40-bit position/button frame.
// Define JSTK_RESP_LED_EN to decode the LED command from the first MOSI byte.
module jstk_spi_responder
    import jstk_spi_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SCLK_MIN_HALF = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [JSTK_POS_W-1:0] joy_x,
    input  logic [JSTK_POS_W-1:0] joy_y,
    input  logic [JSTK_BTN_W-1:0] btn,
    input  logic                  SS,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [1:0]            led,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1) + 1;

    if (SYNC_STAGES < 2 || SCLK_MIN_HALF < 2) begin : g_bad_cfg
        $error("jstk_spi_responder: SYNC_STAGES and SCLK_MIN_HALF must be at least 2");
    end

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_rise, sclk_fall, unused_sclk_lvl;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .clr(clr), .d(SS), .q(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .clr(clr), .d(SCLK), .q(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    jstk_state_e                state_q, state_d;
    logic [JSTK_CNT_W-1:0]      cnt_q, cnt_d;
    logic [JSTK_FRAME_BITS-1:0] sr_q, sr_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [SETTLE_W-1:0]        settle_q, settle_d;
    logic                       arm_q, arm_d;
    logic                       settle_done;

    // After clr the synchronizer holds its reset value, so SS must be seen high
    // with real samples before a falling edge may start a frame.
    assign settle_done = (settle_q == SETTLE_W'(SYNC_STAGES));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        settle_d = settle_done ? settle_q : settle_q + 1'b1;
        arm_d    = arm_q | (settle_done & ss_lvl);

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && arm_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_d    = jstk_pack_frame(joy_x, joy_y, btn);
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    err_d   = (cnt_q != '0);
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == JSTK_CNT_W'(JSTK_FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                    end
                end else if (sclk_fall) begin
                    sr_d = {sr_q[JSTK_FRAME_BITS-2:0], 1'b0};
                end
            end
            ST_HOLD: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            settle_q <= '0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            settle_q <= settle_d;
            arm_q    <= arm_d;
        end
    end

    assign MISO       = (state_q == ST_SHIFT) & sr_q[JSTK_FRAME_BITS-1];
    assign frame_done = done_q;
    assign frame_err  = err_q;

`ifdef JSTK_RESP_LED_EN
    logic                     mosi_lvl, unused_mosi_rise, unused_mosi_fall;
    logic [JSTK_CMD_BITS-1:0] cmd_q, cmd_d, cmd_full;
    logic                     pend_q, pend_d;
    logic [1:0]               led_nxt_q, led_nxt_d;
    logic [1:0]               led_q, led_d;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .clr(clr), .d(MOSI), .q(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign cmd_full = {cmd_q[JSTK_CMD_BITS-2:0], mosi_lvl};

    always_comb begin
        cmd_d     = cmd_q;
        pend_d    = 1'b0;
        led_nxt_d = led_nxt_q;
        led_d     = pend_q ? led_nxt_q : led_q;
        if (state_q == ST_SHIFT && !ss_rise && sclk_rise && cnt_q < JSTK_CNT_W'(JSTK_CMD_BITS)) begin
            cmd_d = cmd_full;
            if (cnt_q == JSTK_CNT_W'(JSTK_CMD_BITS - 1) && cmd_full[7:2] == JSTK_LED_CMD) begin
                pend_d    = 1'b1;
                led_nxt_d = cmd_full[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cmd_q     <= '0;
            pend_q    <= 1'b0;
            led_nxt_q <= 2'b00;
            led_q     <= 2'b00;
        end else begin
            cmd_q     <= cmd_d;
            pend_q    <= pend_d;
            led_nxt_q <= led_nxt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;
`else
    logic unused_mosi;
    assign unused_mosi = MOSI;
    assign led         = 2'b00;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: an SPI master drives frames while a
// frame-level model predicts MISO, led and frame pulses every settled cycle.
module tb_jstk_spi_responder;

    localparam int unsigned STAGES = 2;
    localparam int          HALF   = 25;   // clk cycles per SCLK half (1 MHz)

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [9:0] joy_x = 10'h2A5;
    logic [9:0] joy_y = 10'h13C;
    logic [2:0] btn   = 3'b101;
    logic       SS    = 1'b1;
    logic       SCLK  = 1'b0;
    logic       MOSI  = 1'b0;
    logic       MISO;
    logic [1:0] led;
    logic       frame_done;
    logic       frame_err;

    always #10 clk = ~clk;

    jstk_spi_responder #(.SYNC_STAGES(STAGES), .SCLK_MIN_HALF(4)) dut (
        .clk(clk), .clr(clr), .joy_x(joy_x), .joy_y(joy_y), .btn(btn),
        .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .led(led),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model state
    logic [39:0] m_frame  = '0;
    bit          m_active = 1'b0;
    int          m_rise   = 0;
    int          m_fall   = 0;
    logic [1:0]  m_led    = 2'b00;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          stable   = 0;
    logic        ss_l = 1'b1, sclk_l = 1'b0, clr_l = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes: x low, x high, y low, y high, buttons
    function automatic logic [39:0] model_frame(input int x, input int y, input int b);
        longint v;
        v = x % 256;
        v = v * 256 + x / 256;
        v = v * 256 + y % 256;
        v = v * 256 + y / 256;
        v = v * 256 + b;
        return v[39:0];
    endfunction

    function automatic logic model_miso();
        if (!m_active || m_rise >= 40) return 1'b0;
        return m_frame[39 - m_fall];
    endfunction

    always @(posedge clk) begin
        #5;
        if (SS !== ss_l || SCLK !== sclk_l || clr !== clr_l) stable = 0;
        else if (stable < 1000) stable++;
        ss_l   = SS;
        sclk_l = SCLK;
        clr_l  = clr;
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (stable >= STAGES + 3 && !clr) begin
            check("miso_track", MISO, model_miso());
            check("led_track", led, m_led);
        end
    end

    task automatic do_frame(input int nclk, input logic [7:0] mbyte, input int chg_at,
                            input logic [9:0] chg_x, input int clr_at,
                            output logic [63:0] rd, output logic [63:0] exp_rd);
        logic eb;
        rd = '0;
        exp_rd = '0;
        @(negedge clk);
        SS = 1'b0;
        m_frame  = model_frame(joy_x, joy_y, btn);
        m_active = 1'b1;
        m_rise   = 0;
        m_fall   = 0;
        repeat (STAGES + 1) @(posedge clk);
        #1 check("miso_first_bit_latency", MISO, m_frame[39]);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if (i == clr_at) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                m_active = 1'b0;
                m_led    = 2'b00;
                check("clr_miso", MISO, 1'b0);
                check("clr_led", led, 2'b00);
                check("clr_done", frame_done, 1'b0);
                check("clr_err", frame_err, 1'b0);
            end
            if (i == chg_at) joy_x = chg_x;
            MOSI = (i < 8) ? mbyte[7 - i] : 1'b0;
            repeat (HALF) @(negedge clk);
            eb = model_miso();
            rd     = {rd[62:0], MISO};
            exp_rd = {exp_rd[62:0], eb};
            SCLK = 1'b1;
            if (m_active && m_rise < 40) begin
                m_rise++;
`ifdef JSTK_RESP_LED_EN
                if (m_rise == 8 && mbyte[7:2] == 6'b100000) m_led = mbyte[1:0];
`endif
            end
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
            if (m_active && m_rise < 40) m_fall++;
        end
        repeat (HALF) @(negedge clk);
        SS = 1'b1;
        MOSI = 1'b0;
        m_active = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic run(input string name, input int nclk, input logic [7:0] mbyte,
                       input int chg_at, input logic [9:0] chg_x, input int clr_at,
                       output logic [63:0] rd);
        int d0, e0, exp_done, exp_err;
        logic [63:0] exp_rd;
        d0 = done_cnt;
        e0 = err_cnt;
        do_frame(nclk, mbyte, chg_at, chg_x, clr_at, rd, exp_rd);
        exp_done = (clr_at < 0 && nclk >= 40) ? 1 : 0;
        exp_err  = (clr_at < 0 && nclk >= 1 && nclk < 40) ? 1 : 0;
        check({name, "_bits"}, rd, exp_rd);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(exp_done));
        check({name, "_err_pulses"}, 64'(err_cnt - e0), 64'(exp_err));
    endtask

    logic [63:0] rd;
    logic [1:0]  led_exp;

    initial begin
`ifdef JSTK_RESP_LED_EN
        led_exp = 2'b10;
`else
        led_exp = 2'b00;
`endif
        repeat (3) @(negedge clk);
        clr = 1'b0;
        check("reset_miso", MISO, 1'b0);
        check("reset_led", led, 2'b00);
        check("reset_done", frame_done, 1'b0);
        check("reset_err", frame_err, 1'b0);
        repeat (20) @(negedge clk);

        run("frame_a", 40, 8'h82, -1, 10'h000, -1, rd);
        check("frame_a_literal", rd[39:0], 40'hA5_02_3C_01_05);
        check("led_after_82", led, led_exp);

        run("frame_b", 40, 8'h43, 10, 10'h3FF, -1, rd);
        check("frame_b_latched", rd[39:0], 40'hA5_02_3C_01_05);
        check("led_after_43", led, led_exp);

        run("frame_c", 40, 8'h00, -1, 10'h000, -1, rd);
        check("frame_c_literal", rd[39:0], 40'hFF_03_3C_01_05);

        run("abort17", 17, 8'h00, -1, 10'h000, -1, rd);
        check("abort17_literal", rd[16:0], 17'h1FE06);

        joy_x = 10'h2A5;
        run("after_abort", 40, 8'h00, -1, 10'h000, -1, rd);
        check("after_abort_literal", rd[39:0], 40'hA5_02_3C_01_05);

        run("empty", 0, 8'h00, -1, 10'h000, -1, rd);

        run("clr20", 40, 8'h82, -1, 10'h000, 20, rd);
        check("clr20_literal", rd[39:0], 40'hA5023_00000);
        check("clr20_led", led, 2'b00);

        run("long45", 45, 8'h00, -1, 10'h000, -1, rd);
        check("long45_literal", rd[44:0], {40'hA5_02_3C_01_05, 5'b00000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (≥2) on SCLK/SS/MOSI.
REQ-002 SHALL have parameter SCLK_MIN_HALF, default 4, minimum clk cycles per SCLK half-period tolerated.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz), sole clock.
REQ-004 SHALL have port clr  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port joy_x  input  10  emulated X position.
REQ-006 SHALL have port joy_y  input  10  emulated Y position.
REQ-007 SHALL have port btn  input  3  {btn2, btn1, stick button}.
REQ-008 SHALL have port SS  input  1  slave select, active low, async to clk.
REQ-009 SHALL have port SCLK  input  1  serial clock, mode 0, async to clk.
REQ-010 SHALL have port MOSI  input  1  master data.
REQ-011 SHALL have port MISO  output  1  slave data.
REQ-012 SHALL have port led  output  2  last valid LED command.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse, full 40-bit frame completed.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse, SS released before bit 40.

Function
REQ-015 SS, SCLK, MOSI SHALL pass through SYNC_STAGES flops before use; edges detected on synchronized values.
REQ-016 States SHALL be IDLE, SHIFT, HOLD; IDLE->SHIFT on SS falling edge; SHIFT->HOLD after 40th SCLK rising edge; SHIFT/HOLD->IDLE on SS rising edge.
REQ-017 On SS falling edge, 40-bit shift register SHALL load {joy_x[7:0], 6'b0, joy_x[9:8], joy_y[7:0], 6'b0, joy_y[9:8], 5'b0, btn}; inputs sampled only then.
REQ-018 MISO SHALL present bit 39 within SYNC_STAGES+1 clk cycles of SS going low; data MSB first.
REQ-019 Shift register SHALL advance one bit on each synchronized SCLK falling edge in SHIFT; 6-bit counter increments on each SCLK rising edge.
REQ-020 MISO SHALL be 0 in IDLE and HOLD; SCLK edges in IDLE/HOLD SHALL be ignored.
REQ-021 frame_done SHALL pulse on the SS rising edge that exits HOLD; frame_err SHALL pulse on SS rising edge from SHIFT with counter 1..39; counter 0 release yields neither.
REQ-022 Simultaneous SS rise and SCLK edge: SS rise SHALL win, edge discarded.
REQ-023 Frames longer than 40 SCLKs SHALL not wrap; extra bits ignored, frame_done still pulses.

Reset
REQ-024 clr SHALL force state IDLE, counter 0, shift register 0, MISO 0, led 2'b00, frame_done 0, frame_err 0, synchronizers to SS=1, SCLK=0, MOSI=0.
REQ-025 clr mid-frame SHALL abort without frame_err; next frame requires a fresh SS falling edge.

Configuration
REQ-026 Macro JSTK_RESP_LED_EN defined: first MOSI byte sampled on SCLK rising edges; at bit 8, if byte[7:2]==6'b100000, led<=byte[1:0] one cycle later; else led unchanged.
REQ-027 Macro undefined: MOSI ignored, led tied 2'b00, no MOSI capture logic.

Structure
REQ-028 Shared package SHALL hold JSTK_FRAME_BITS=40, JSTK_LED_CMD=6'b100000, state encoding, byte-layout constants reused by joystick reader.
REQ-029 Synchronizer+edge detector SHALL be sub-module sync_edge (parameter STAGES), instantiated per SCLK, SS, MOSI.

Verification
REQ-030 joy_x=10'h2A5, joy_y=10'h13C, btn=3'b101, 40 SCLKs at 1 MHz -> master reads 40'hA5_02_3C_01_05, one frame_done, no frame_err.
REQ-031 joy_x changed to 10'h3FF mid-frame -> frame still returns latched 10'h2A5; next frame returns FF_03.
REQ-032 SS released after 17 SCLKs -> frame_err pulse once, MISO 0, next full frame correct.
REQ-033 LED_EN defined, MOSI first byte 8'h82 -> led=2'b10 after bit 8; byte 8'h43 -> led unchanged; LED_EN undefined -> led 2'b00 always.
REQ-034 clr asserted at SCLK 20 -> all outputs reset values, no pulses; 45-SCLK frame -> trailing bits 0, one frame_done.
